adder_bist_checker: RTL and testbench



---
 rtl/adder_bist_pkg.sv | 8 +
 rtl/bist_vector_gen.sv | 28 ++
 rtl/adder_bist_checker.sv | 54 +++++
 tb/tb_adder_bist_checker.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/adder_bist_pkg.sv
// adder_bist_pkg: shared state encoding and reference sum for the adder self-test engine.
package adder_bist_pkg;
  typedef enum logic [1:0] {IDLE, APPLY, DONE} state_t;
  localparam int MAX_W = 8;
  function automatic logic [MAX_W:0] expected_sum(input logic [MAX_W-1:0] x, input logic [MAX_W-1:0] y);
    return {1'b0, x} + {1'b0, y};
  endfunction
endpackage

// File: rtl/bist_vector_gen.sv
// bist_vector_gen: walks every operand pair, holding each for SETTLE+1 cycles.
module bist_vector_gen #(
  parameter int WIDTH = 1,
  parameter int SETTLE = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               en,
  output logic [2*WIDTH-1:0] vec,
  output logic               strobe,
  output logic               last
);
  localparam int VW = 2*WIDTH;
  logic [3:0] s;
  assign strobe = s == 4'(SETTLE);
  assign last = &vec;
  // the final vector is held so the operands stay visible after the run
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      vec <= '0;
      s <= '0;
    end else if (en) begin
      s <= strobe ? '0 : s + 4'd1;
      if (strobe && !last) vec <= vec + VW'(1);
    end
  end
endmodule

// File: rtl/adder_bist_checker.sv
// adder_bist_checker: exhaustive self-test of a combinational adder, reporting errors and first failing vector.
module adder_bist_checker
  import adder_bist_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int SETTLE = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic [WIDTH-1:0]   a,
  output logic [WIDTH-1:0]   b,
  input  logic [WIDTH-1:0]   sum,
  input  logic               cout,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [2*WIDTH:0]   err_count,
  output logic [WIDTH-1:0]   fail_a,
  output logic [WIDTH-1:0]   fail_b
);
  localparam int EW = 2*WIDTH+1;
  state_t state, state_d;
  logic [2*WIDTH-1:0] vec;
  logic strobe, last, clear, mismatch;
  bist_vector_gen #(.WIDTH(WIDTH), .SETTLE(SETTLE)) u_gen (
    .clk(clk), .rst_n(rst_n), .clear(clear), .en(busy),
    .vec(vec), .strobe(strobe), .last(last)
  );
  assign {a, b} = vec;
  assign busy = state == APPLY;
  assign done = state == DONE;
  assign pass = done && err_count == '0;
  assign mismatch = (MAX_W+1)'({cout, sum}) != expected_sum(MAX_W'(a), MAX_W'(b));
  always_comb begin
    clear = start && state != APPLY;
    state_d = clear ? APPLY : (busy && strobe && last) ? DONE : state;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else state <= state_d;
  end
  // a zero error count doubles as the "no failure captured yet" flag
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      err_count <= '0;
      fail_a <= '0;
      fail_b <= '0;
    end else if (busy && strobe && mismatch) begin
      err_count <= err_count + EW'(1);
      if (err_count == '0) {fail_a, fail_b} <= vec;
    end
  end
endmodule

// File: tb/tb_adder_bist_checker.sv
// tb_adder_bist_checker: directed runs of several checker instances against good, faulty and delayed adders.
module tb_adder_bist_checker;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, clr = 1'b0, fault1 = 1'b0;
  int errors = 0, checks = 0;
  int bc [5];
  always #5 clk = ~clk;

  logic a1, b1, s1, c1, busy1, done1, pass1, fa1, fb1;
  logic [2:0] err1;
  logic a2, b2, s2, c2, busy2, done2, pass2, fa2, fb2;
  logic [2:0] err2;
  logic [1:0] a3, b3, s3, fa3, fb3;
  logic c3, busy3, done3, pass3;
  logic [4:0] err3;
  logic a4, b4, s4, c4, busy4, done4, pass4, fa4, fb4;
  logic [2:0] err4;
  logic a5, b5, s5, c5, busy5, done5, pass5, fa5, fb5;
  logic [2:0] err5;
  logic [1:0] p1_4, p2_4, p1_5, p2_5;

  assign s1 = a1 ^ b1;
  assign c1 = fault1 ? 1'b0 : (a1 & b1);
  assign s2 = ~(a2 ^ b2);
  assign c2 = a2 & b2;
  assign {c3, s3} = {1'b0, a3} + {1'b0, b3};
  assign {c4, s4} = p2_4;
  assign {c5, s5} = p2_5;

  always @(posedge clk) begin
    if (!rst_n) begin
      p1_4 <= '0; p2_4 <= '0; p1_5 <= '0; p2_5 <= '0;
    end else begin
      p1_4 <= {a4 & b4, a4 ^ b4}; p2_4 <= p1_4;
      p1_5 <= {a5 & b5, a5 ^ b5}; p2_5 <= p1_5;
    end
  end

  always @(posedge clk) begin
    bc[0] <= clr ? 0 : bc[0] + 32'(busy1);
    bc[1] <= clr ? 0 : bc[1] + 32'(busy2);
    bc[2] <= clr ? 0 : bc[2] + 32'(busy3);
    bc[3] <= clr ? 0 : bc[3] + 32'(busy4);
    bc[4] <= clr ? 0 : bc[4] + 32'(busy5);
  end

  adder_bist_checker #(.WIDTH(1), .SETTLE(1)) u1 (.clk(clk), .rst_n(rst_n), .start(start), .a(a1), .b(b1),
    .sum(s1), .cout(c1), .busy(busy1), .done(done1), .pass(pass1), .err_count(err1), .fail_a(fa1), .fail_b(fb1));
  adder_bist_checker #(.WIDTH(1), .SETTLE(0)) u2 (.clk(clk), .rst_n(rst_n), .start(start), .a(a2), .b(b2),
    .sum(s2), .cout(c2), .busy(busy2), .done(done2), .pass(pass2), .err_count(err2), .fail_a(fa2), .fail_b(fb2));
  adder_bist_checker #(.WIDTH(2), .SETTLE(1)) u3 (.clk(clk), .rst_n(rst_n), .start(start), .a(a3), .b(b3),
    .sum(s3), .cout(c3), .busy(busy3), .done(done3), .pass(pass3), .err_count(err3), .fail_a(fa3), .fail_b(fb3));
  adder_bist_checker #(.WIDTH(1), .SETTLE(3)) u4 (.clk(clk), .rst_n(rst_n), .start(start), .a(a4), .b(b4),
    .sum(s4), .cout(c4), .busy(busy4), .done(done4), .pass(pass4), .err_count(err4), .fail_a(fa4), .fail_b(fb4));
  adder_bist_checker #(.WIDTH(1), .SETTLE(0)) u5 (.clk(clk), .rst_n(rst_n), .start(start), .a(a5), .b(b5),
    .sum(s5), .cout(c5), .busy(busy5), .done(done5), .pass(pass5), .err_count(err5), .fail_a(fa5), .fail_b(fb5));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic kick();
    start = 1'b1;
    clr = 1'b1;
    @(negedge clk);
    start = 1'b0;
    clr = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy3), 0);
    chk("rst_done", 32'(done3), 0);
    chk("rst_pass", 32'(pass3), 0);
    chk("rst_err", 32'(err3), 0);
    chk("rst_ab", 32'({a3, b3}), 0);
    chk("rst_fail", 32'({fa3, fb3}), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_busy", 32'(busy1), 0);

    kick();
    for (int k = 0; k < 40; k++) begin
      if (k < 8) chk("u1_vec", 32'({a1, b1}), 32'(k / 2));
      if (k < 32) chk("u3_vec", 32'({a3, b3}), 32'(k / 2));
      if (k == 7) begin
        chk("u1_busy_last", 32'(busy1), 1);
        chk("u1_done_early", 32'(done1), 0);
      end
      if (k == 8) begin
        chk("u1_busy_off", 32'(busy1), 0);
        chk("u1_done", 32'(done1), 1);
      end
      @(negedge clk);
    end
    chk("a_u1_len", 32'(bc[0]), 8);
    chk("a_u1_pass", 32'(pass1), 1);
    chk("a_u1_err", 32'(err1), 0);
    chk("a_u1_fail", 32'({fa1, fb1}), 0);
    chk("a_u1_hold", 32'({a1, b1}), 3);
    chk("a_u2_len", 32'(bc[1]), 4);
    chk("a_u2_err", 32'(err2), 4);
    chk("a_u2_fail", 32'({fa2, fb2}), 0);
    chk("a_u2_pass", 32'(pass2), 0);
    chk("a_u2_done", 32'(done2), 1);
    chk("a_u3_len", 32'(bc[2]), 32);
    chk("a_u3_pass", 32'(pass3), 1);
    chk("a_u3_err", 32'(err3), 0);
    chk("a_u4_len", 32'(bc[3]), 16);
    chk("a_u4_pass", 32'(pass4), 1);
    chk("a_u5_err_nz", 32'(err5 != 0), 1);
    chk("a_u5_pass", 32'(pass5), 0);

    fault1 = 1'b1;
    kick();
    repeat (40) @(negedge clk);
    chk("b_u1_err", 32'(err1), 1);
    chk("b_u1_fail", 32'({fa1, fb1}), 3);
    chk("b_u1_pass", 32'(pass1), 0);
    chk("b_u2_err", 32'(err2), 4);
    chk("b_u3_len", 32'(bc[2]), 32);
    chk("b_u3_err", 32'(err3), 0);
    chk("b_u3_pass", 32'(pass3), 1);

    kick();
    repeat (2) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (40) @(negedge clk);
    chk("c_u3_len", 32'(bc[2]), 32);
    chk("c_u1_len", 32'(bc[0]), 8);
    chk("c_u1_err", 32'(err1), 1);

    kick();
    repeat (4) @(negedge clk);
    chk("d_busy_pre", 32'(busy3), 1);
    rst_n = 1'b0;
    start = 1'b1;
    @(negedge clk);
    chk("d_busy", 32'(busy3), 0);
    chk("d_done", 32'(done3), 0);
    chk("d_ab", 32'({a3, b3}), 0);
    chk("d_err3", 32'(err3), 0);
    chk("d_err2", 32'(err2), 0);
    chk("d_done2", 32'(done2), 0);
    chk("d_fail1", 32'({fa1, fb1}), 0);
    rst_n = 1'b1;
    start = 1'b0;
    @(negedge clk);
    chk("d_idle", 32'(busy3), 0);

    fault1 = 1'b0;
    kick();
    repeat (40) @(negedge clk);
    chk("e_u3_len", 32'(bc[2]), 32);
    chk("e_u3_pass", 32'(pass3), 1);
    chk("e_u1_len", 32'(bc[0]), 8);
    chk("e_u1_pass", 32'(pass1), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
